// File: rtl/config_regmap_if.sv
// config_regmap_if: request/response channel of the configuration register map.
//   req_valid/req_ready  request handshake (master -> slave)
//   req_write            1 = write, 0 = read
//   req_addr             register address
//   req_wdata            write data
//   rsp_valid/rsp_ready  response handshake (slave -> master)
//   rsp_rdata            read data (0 on writes and errors)
//   rsp_err              request rejected
interface config_regmap_if #(
  parameter int ADDRWIDTH = 8,
  parameter int REGWIDTH  = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDRWIDTH-1:0] req_addr;
  logic [REGWIDTH-1:0]  req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [REGWIDTH-1:0]  rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/config_regmap.sv
// config_regmap: shadowed configuration register file with commit, lock and
// a background XOR checksum.
//   clk, reset_n    clock, asynchronous active-low reset
//   bus (slave)     request/response channel, one outstanding response
//   commit          external commit pulse (multi-chip synchronous update)
//   config_bits     active register contents, reg i at [i*REGWIDTH +: REGWIDTH]
//   config_update   one-cycle pulse after the active registers are loaded
//   checksum        XOR of all active registers
//   checksum_valid  checksum reflects the current active contents
//   locked          sticky write lock
// Address map: 0..NUMREGS-1 data, NUMREGS CTRL {read_shadow,lock,shadow_mode},
// NUMREGS+1 COMMIT (write-only), NUMREGS+2 CHECKSUM (read-only).
module config_regmap #(
  parameter int NUMREGS   = 64,
  parameter int REGWIDTH  = 8,
  parameter int ADDRWIDTH = 8,
  parameter logic [NUMREGS*REGWIDTH-1:0] DEFAULTS = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  config_regmap_if.slave               bus,
  input  logic                         commit,
  output logic [NUMREGS*REGWIDTH-1:0]  config_bits,
  output logic                         config_update,
  output logic [REGWIDTH-1:0]          checksum,
  output logic                         checksum_valid,
  output logic                         locked
);

  localparam int IDXW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
  localparam logic [ADDRWIDTH-1:0] A_CTRL   = ADDRWIDTH'(NUMREGS);
  localparam logic [ADDRWIDTH-1:0] A_COMMIT = ADDRWIDTH'(NUMREGS + 1);
  localparam logic [ADDRWIDTH-1:0] A_CSUM   = ADDRWIDTH'(NUMREGS + 2);
  localparam logic [IDXW-1:0]      LAST_IDX = IDXW'(NUMREGS - 1);

  typedef struct packed {
    logic                err;
    logic [REGWIDTH-1:0] rdata;
  } rsp_t;

  typedef enum logic {IDLE, SCAN} cs_state_t;

  // register storage
  logic [NUMREGS-1:0][REGWIDTH-1:0] shadow;
  logic [NUMREGS-1:0][REGWIDTH-1:0] active;
  logic shadow_mode, lock, read_shadow;

  // request decode
  logic            accept, wr;
  logic            is_data, is_ctrl, is_commit, is_csum, is_bad;
  logic            req_err;
  logic            data_wr, ctrl_wr, commit_now, direct_ld, active_ld;
  logic [IDXW-1:0] widx;
  logic [2:0]      ctrl_w;
  logic [NUMREGS-1:0] hit;
  logic [REGWIDTH-1:0] rd_data;

  rsp_t rsp_q;
  logic rsp_vld_q;

  assign bus.req_ready = !rsp_vld_q | bus.rsp_ready;
  assign accept        = bus.req_valid & bus.req_ready;
  assign wr            = accept & bus.req_write;

  assign is_data   = bus.req_addr <  A_CTRL;
  assign is_ctrl   = bus.req_addr == A_CTRL;
  assign is_commit = bus.req_addr == A_COMMIT;
  assign is_csum   = bus.req_addr == A_CSUM;
  assign is_bad    = bus.req_addr >  A_CSUM;

  assign widx   = bus.req_addr[IDXW-1:0];
  assign ctrl_w = 3'(bus.req_wdata);

  // Lock only fences data and CTRL; COMMIT keeps working so a locked
  // device can still follow a system-wide synchronous update.
  assign req_err = bus.req_write ? (is_bad | is_csum | ((is_data | is_ctrl) & lock))
                                 : is_bad;

  assign data_wr    = wr & is_data & !lock;
  assign ctrl_wr    = wr & is_ctrl & !lock;
  assign commit_now = commit | (wr & is_commit);
  assign direct_ld  = data_wr & !shadow_mode;
  assign active_ld  = commit_now | direct_ld;

  // per-register write strobe
  for (genvar i = 0; i < NUMREGS; i++) begin : g_hit
    assign hit[i] = data_wr & (widx == IDXW'(i));
  end

  // Commit takes priority over a direct write: active gets the pre-write
  // shadow, the new value lands only in shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMREGS; i++) begin
        shadow[i] <= DEFAULTS[i*REGWIDTH +: REGWIDTH];
        active[i] <= DEFAULTS[i*REGWIDTH +: REGWIDTH];
      end
    end else begin
      for (int i = 0; i < NUMREGS; i++) begin
        if (hit[i]) shadow[i] <= bus.req_wdata;
        if (commit_now)
          active[i] <= shadow[i];
        else if (hit[i] && !shadow_mode)
          active[i] <= bus.req_wdata;
      end
    end
  end

  // CTRL; lock is sticky until reset (ctrl_wr already excludes locked state)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_mode <= 1'b0;
      lock        <= 1'b0;
      read_shadow <= 1'b0;
    end else if (ctrl_wr) begin
      shadow_mode <= ctrl_w[0];
      lock        <= ctrl_w[1];
      read_shadow <= ctrl_w[2];
    end
  end

  // read mux; writes, errors and COMMIT reads return 0
  always_comb begin
    rd_data = '0;
    if (!bus.req_write && !req_err) begin
      if (is_data)
        rd_data = read_shadow ? shadow[widx] : active[widx];
      else if (is_ctrl)
        rd_data = REGWIDTH'({read_shadow, lock, shadow_mode});
      else if (is_csum)
        rd_data = (REGWIDTH == 1) ? REGWIDTH'(checksum_valid) : checksum;
    end
  end

  // single response slot, held until consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else if (accept) begin
      rsp_vld_q   <= 1'b1;
      rsp_q.err   <= req_err;
      rsp_q.rdata <= rd_data;
    end else if (bus.rsp_ready) begin
      rsp_vld_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_rdata = rsp_q.rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) config_update <= 1'b0;
    else          config_update <= active_ld;
  end

  // ---------------- checksum scanner ----------------
  cs_state_t           state, state_n;
  logic [IDXW-1:0]     idx, idx_n;
  logic [REGWIDTH-1:0] acc, acc_n, cs_n;
  logic                csv_n;
  logic                start_pend;   // forces a scan on the first cycle out of reset

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      checksum       <= '0;
      checksum_valid <= 1'b0;
      start_pend     <= 1'b1;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      acc            <= acc_n;
      checksum       <= cs_n;
      checksum_valid <= csv_n;
      start_pend     <= 1'b0;
    end
  end

  // Any active load (re)starts the scan from index 0, so a partially
  // accumulated XOR of stale contents is never published.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc_n   = acc;
    cs_n    = checksum;
    csv_n   = checksum_valid;
    if (active_ld || start_pend) begin
      state_n = SCAN;
      idx_n   = '0;
      acc_n   = '0;
      csv_n   = 1'b0;
    end else begin
      case (state)
        SCAN: begin
          acc_n = acc ^ active[idx];
          if (idx == LAST_IDX) begin
            cs_n    = acc_n;
            csv_n   = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n = idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign config_bits = active;
  assign locked      = lock;

endmodule
